reg4_seq_ctrl: RTL and testbench
================================

Name: reg4_seq_ctrl

Overview:
Command sequencer for the 4-bit universal register datapath, with activity (toggle) accounting. Accepts load/shift/rotate commands over a valid/ready handshake. Steps the register through its mode inputs for the commanded number of cycles and counts output bit toggles for switching-power estimation (P = V²·C·toggles, computed downstream). Blocks new commands once a programmable toggle budget is reached.

Parameters:
WIDTH, 4, register width driven and monitored
CNT_W, 16, toggle counter / budget width

Ports:
CLK  in  1  clock, rising edge
RESET_L  in  1  asynchronous active-low reset
CMD_VALID  in  1  command request
CMD_READY  out  1  controller can accept a command
CMD_OP  in  2  00 load, 01 shift left, 10 shift right, 11 rotate left
CMD_CNT  in  3  shift/rotate step count, 0..7; ignored for load
CMD_DATA  in  WIDTH  load value; bit 0 is the serial fill bit for shifts
REG_Q  in  WIDTH  register output feedback
REG_MODO  out  2  register mode: 00 hold, 01 parallel load, 10 shift left, 11 shift right
REG_D  out  WIDTH  parallel load data
REG_S_IN  out  1  serial input
DONE  out  1  one-cycle pulse on command completion
CLR_CNT  in  1  synchronous clear of the toggle counter
BUDGET  in  CNT_W  toggle budget; 0 disables it
BUDGET_HIT  out  1  budget reached
TOGGLE_CNT  out  CNT_W  cumulative REG_Q bit toggles, saturating

Behaviour:
- Reset (RESET_L=0, asynchronous) forces the following; reset mid-command aborts the command with no DONE:
  - state IDLE
  - REG_MODO=00, REG_D=0, REG_S_IN=0, DONE=0
  - TOGGLE_CNT=0, internal prev_q=0, latched command cleared
  - CMD_READY=1 after release when the budget is not hit
- Outputs are decoded from registered state and latched command only. No combinational path from CMD_* to REG_*.
- FSM states: IDLE, LOAD, STEP, FIN.
  - IDLE: REG_MODO=00.
    - CMD_READY = !BUDGET_HIT.
    - Accept on CMD_VALID & CMD_READY: latch op, cnt, data.
    - Next state: op=00 → LOAD; op≠00 with cnt=0 → FIN (no-op); otherwise STEP with rem=cnt.
  - LOAD: REG_MODO=01, REG_D=latched data, one cycle, then FIN.
  - STEP: one cycle per step, rem decrements each cycle; rem=1 → FIN.
    - op 01: REG_MODO=10, REG_S_IN=data[0].
    - op 10: REG_MODO=11, REG_S_IN=data[0].
    - op 11: REG_MODO=10, REG_S_IN=REG_Q[WIDTH-1] (live feedback).
  - FIN: DONE=1, REG_MODO=00, CMD_READY=0, then IDLE.
- Timing:
  - Load: accept at cycle t, MODO=01 at t+1, DONE at t+2, next accept possible at t+3.
  - Shift/rotate of n steps: DONE at t+n+1.
- CMD_* inputs are ignored outside an IDLE accept; the command is latched, so inputs may change after acceptance.
- Toggle accounting, every cycle in every state:
  - TOGGLE_CNT += popcount(REG_Q ^ prev_q), saturating at 2^CNT_W-1 (never wraps).
  - prev_q <= REG_Q.
  - CLR_CNT=1: TOGGLE_CNT <= 0 that cycle; that cycle's toggles are discarded and prev_q still updates.
- Budget:
  - BUDGET_HIT = (BUDGET≠0) & (TOGGLE_CNT ≥ BUDGET), combinational from the registered count.
  - Checked only at acceptance; an in-flight command always completes.
  - Budget hit in the same cycle as CMD_VALID: the command is not accepted.

Test Plan:
1. Reset with REG_Q=0, then release → all outputs 0 and CMD_READY=1; assert RESET_L low asynchronously mid-cycle → outputs clear without waiting for a clock edge.
2. From Q=0000, issue load of 1010 (model register in bench) → MODO=01 and REG_D=1010 at t+1, DONE at t+2, TOGGLE_CNT=2.
3. Then rotate left with CMD_CNT=3 → MODO=10 for exactly 3 cycles with S_IN=Q[3] each step; Q sequence 0101, 1010, 0101; DONE at t+4; TOGGLE_CNT=14.
4. BUDGET=14 after scenario 3 with CMD_VALID held → BUDGET_HIT=1 and CMD_READY=0 indefinitely; pulse CLR_CNT → TOGGLE_CNT=0, CMD_READY=1 next cycle, command accepted.
5. Shift right with CMD_CNT=0 → no cycle with MODO≠00, DONE at t+1, TOGGLE_CNT unchanged. Then shift left with CMD_CNT=4 and data[0]=1 from 0000 → Q=1111 after 4 steps.
6. Reset during STEP of a 7-step rotate (after 3 steps) → MODO=00, no DONE pulse, TOGGLE_CNT=0, back in IDLE. Separately, with CNT_W=4, exceed 15 toggles → TOGGLE_CNT holds 15.

Source files
------------

// File: rtl/reg4_seq_ctrl_if.sv
// Command, register-datapath and toggle-accounting signals shared between the
// command source / register model (master) and the sequencer (slave).
interface reg4_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
);
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [1:0]       CMD_OP;
  logic [2:0]       CMD_CNT;
  logic [WIDTH-1:0] CMD_DATA;
  logic [WIDTH-1:0] REG_Q;
  logic [1:0]       REG_MODO;
  logic [WIDTH-1:0] REG_D;
  logic             REG_S_IN;
  logic             DONE;
  logic             CLR_CNT;
  logic [CNT_W-1:0] BUDGET;
  logic             BUDGET_HIT;
  logic [CNT_W-1:0] TOGGLE_CNT;

  modport master (
    output CMD_VALID, CMD_OP, CMD_CNT, CMD_DATA, REG_Q, CLR_CNT, BUDGET,
    input  CMD_READY, REG_MODO, REG_D, REG_S_IN, DONE, BUDGET_HIT, TOGGLE_CNT
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_CNT, CMD_DATA, REG_Q, CLR_CNT, BUDGET,
    output CMD_READY, REG_MODO, REG_D, REG_S_IN, DONE, BUDGET_HIT, TOGGLE_CNT
  );
endinterface

// File: rtl/reg4_seq_ctrl.sv
// Command sequencer for the 4-bit universal register: steps the register mode
// inputs for load/shift/rotate commands and keeps a saturating count of output
// bit toggles, refusing new commands once the toggle budget is reached.
module reg4_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input logic           CLK,
  input logic           RESET_L,
  reg4_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, STEP, FIN} state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_ROTL = 2'b11;

  localparam logic [1:0] MODO_HOLD = 2'b00;
  localparam logic [1:0] MODO_LOAD = 2'b01;
  localparam logic [1:0] MODO_SHL  = 2'b10;
  localparam logic [1:0] MODO_SHR  = 2'b11;

  state_t           state;
  logic [1:0]       op_q;
  logic [2:0]       rem;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       modo_q;
  logic             done_q;
  logic [WIDTH-1:0] prev_q;
  logic [CNT_W-1:0] toggle_cnt;
  logic             budget_hit;
  logic             cmd_ready;

  // Number of bits set in a register-width vector, widened to the counter.
  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] x);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + {{(CNT_W-1){1'b0}}, x[i]};
    end
    return n;
  endfunction

  // Unsigned add that pins at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  assign budget_hit = (bus.BUDGET != '0) && (toggle_cnt >= bus.BUDGET);
  assign cmd_ready  = (state == IDLE) && !budget_hit;

  // Command FSM; mode and done are registered alongside the state.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state  <= IDLE;
      op_q   <= OP_LOAD;
      rem    <= '0;
      data_q <= '0;
      modo_q <= MODO_HOLD;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.CMD_VALID && cmd_ready) begin
            op_q   <= bus.CMD_OP;
            rem    <= bus.CMD_CNT;
            data_q <= bus.CMD_DATA;
            if (bus.CMD_OP == OP_LOAD) begin
              state  <= LOAD;
              modo_q <= MODO_LOAD;
            end else if (bus.CMD_CNT == 3'd0) begin
              // Zero-step shift/rotate completes without touching the register.
              state  <= FIN;
              done_q <= 1'b1;
            end else begin
              state  <= STEP;
              modo_q <= (bus.CMD_OP == OP_SHR) ? MODO_SHR : MODO_SHL;
            end
          end
        end
        LOAD: begin
          state  <= FIN;
          modo_q <= MODO_HOLD;
          done_q <= 1'b1;
        end
        STEP: begin
          rem <= rem - 3'd1;
          if (rem == 3'd1) begin
            state  <= FIN;
            modo_q <= MODO_HOLD;
            done_q <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          modo_q <= MODO_HOLD;
        end
      endcase
    end
  end

  // Toggle accounting runs every cycle regardless of the FSM state.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      prev_q     <= '0;
      toggle_cnt <= '0;
    end else begin
      prev_q <= bus.REG_Q;
      if (bus.CLR_CNT) begin
        toggle_cnt <= '0;
      end else begin
        toggle_cnt <= sat_add(toggle_cnt, popcount(bus.REG_Q ^ prev_q));
      end
    end
  end

  assign bus.CMD_READY  = cmd_ready;
  assign bus.REG_MODO   = modo_q;
  assign bus.DONE       = done_q;
  assign bus.BUDGET_HIT = budget_hit;
  assign bus.TOGGLE_CNT = toggle_cnt;
  assign bus.REG_D      = (state == LOAD) ? data_q : '0;
  // Rotate feeds the register MSB straight back in; shifts use the latched fill bit.
  assign bus.REG_S_IN   = (state != STEP)   ? 1'b0 :
                          (op_q == OP_ROTL) ? bus.REG_Q[WIDTH-1] : data_q[0];

endmodule

// File: tb/tb_reg4_seq_ctrl.sv
// Directed bench for reg4_seq_ctrl: a behavioural 4-bit universal register
// closes the loop on REG_Q; a second instance with a 4-bit counter exercises
// toggle-count saturation.
module tb_reg4_seq_ctrl;

  logic CLK;
  logic RESET_L;
  int   n_cmp;
  int   n_err;

  reg4_seq_ctrl_if #(.WIDTH(4), .CNT_W(16)) bus();
  reg4_seq_ctrl_if #(.WIDTH(4), .CNT_W(4))  bus2();

  reg4_seq_ctrl #(.WIDTH(4), .CNT_W(16)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .bus(bus)
  );
  reg4_seq_ctrl #(.WIDTH(4), .CNT_W(4)) dut2 (
    .CLK(CLK), .RESET_L(RESET_L), .bus(bus2)
  );

  logic [3:0] q_model;
  logic [3:0] q2;
  logic [3:0] exp_q [3];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural universal register driven by the controller outputs.
  always @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) q_model <= 4'b0000;
    else begin
      case (bus.REG_MODO)
        2'b01:   q_model <= bus.REG_D;
        2'b10:   q_model <= {q_model[2:0], bus.REG_S_IN};
        2'b11:   q_model <= {bus.REG_S_IN, q_model[3:1]};
        default: q_model <= q_model;
      endcase
    end
  end

  assign bus.REG_Q  = q_model;
  assign bus2.REG_Q = q2;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_q[0] = 4'b0101;
    exp_q[1] = 4'b1010;
    exp_q[2] = 4'b0101;
    RESET_L = 1'b0;
    bus.CMD_VALID = 1'b0; bus.CMD_OP = 2'b00; bus.CMD_CNT = 3'd0; bus.CMD_DATA = 4'h0;
    bus.CLR_CNT = 1'b0; bus.BUDGET = 16'd0;
    bus2.CMD_VALID = 1'b0; bus2.CMD_OP = 2'b00; bus2.CMD_CNT = 3'd0; bus2.CMD_DATA = 4'h0;
    bus2.CLR_CNT = 1'b0; bus2.BUDGET = 4'd0;
    q2 = 4'h0;

    // Reset and release
    step(); step();
    check_eq("rst_modo", 32'(bus.REG_MODO), 32'd0);
    check_eq("rst_tcnt", 32'(bus.TOGGLE_CNT), 32'd0);
    RESET_L = 1'b1;
    step();
    check_eq("rel_ready", 32'(bus.CMD_READY), 32'd1);
    check_eq("rel_modo", 32'(bus.REG_MODO), 32'd0);
    check_eq("rel_d", 32'(bus.REG_D), 32'd0);
    check_eq("rel_sin", 32'(bus.REG_S_IN), 32'd0);
    check_eq("rel_done", 32'(bus.DONE), 32'd0);
    check_eq("rel_hit", 32'(bus.BUDGET_HIT), 32'd0);

    // Load 1010 from 0000
    bus.CMD_VALID = 1'b1; bus.CMD_OP = 2'b00; bus.CMD_DATA = 4'b1010;
    step();
    bus.CMD_VALID = 1'b0; bus.CMD_DATA = 4'b0000;
    check_eq("ld_modo", 32'(bus.REG_MODO), 32'd1);
    check_eq("ld_d", 32'(bus.REG_D), 32'hA);
    check_eq("ld_ready", 32'(bus.CMD_READY), 32'd0);
    check_eq("ld_nodone", 32'(bus.DONE), 32'd0);
    step();
    check_eq("ld_done", 32'(bus.DONE), 32'd1);
    check_eq("ld_fin_modo", 32'(bus.REG_MODO), 32'd0);
    check_eq("ld_fin_ready", 32'(bus.CMD_READY), 32'd0);
    step();
    check_eq("ld_done_end", 32'(bus.DONE), 32'd0);
    check_eq("ld_ready2", 32'(bus.CMD_READY), 32'd1);
    check_eq("ld_q", 32'(q_model), 32'hA);
    check_eq("ld_tcnt", 32'(bus.TOGGLE_CNT), 32'd2);

    // Rotate left by 3
    bus.CMD_VALID = 1'b1; bus.CMD_OP = 2'b11; bus.CMD_CNT = 3'd3; bus.CMD_DATA = 4'b0000;
    step();
    bus.CMD_VALID = 1'b0; bus.CMD_OP = 2'b00; bus.CMD_CNT = 3'd0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rot_modo%0d", i), 32'(bus.REG_MODO), 32'd2);
      check_eq($sformatf("rot_sin%0d", i), 32'(bus.REG_S_IN), 32'(q_model[3]));
      check_eq($sformatf("rot_nodone%0d", i), 32'(bus.DONE), 32'd0);
      step();
      check_eq($sformatf("rot_q%0d", i), 32'(q_model), 32'(exp_q[i]));
    end
    check_eq("rot_done", 32'(bus.DONE), 32'd1);
    check_eq("rot_fin_modo", 32'(bus.REG_MODO), 32'd0);
    step();
    check_eq("rot_tcnt", 32'(bus.TOGGLE_CNT), 32'd14);
    check_eq("rot_done_end", 32'(bus.DONE), 32'd0);

    // Budget blocks acceptance until the counter is cleared
    bus.BUDGET = 16'd14;
    bus.CMD_VALID = 1'b1; bus.CMD_OP = 2'b00; bus.CMD_DATA = 4'b0000;
    #1;
    check_eq("bud_hit", 32'(bus.BUDGET_HIT), 32'd1);
    check_eq("bud_ready", 32'(bus.CMD_READY), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("bud_block%0d", i), 32'(bus.CMD_READY), 32'd0);
      check_eq($sformatf("bud_modo%0d", i), 32'(bus.REG_MODO), 32'd0);
    end
    bus.CLR_CNT = 1'b1;
    step();
    bus.CLR_CNT = 1'b0;
    check_eq("clr_tcnt", 32'(bus.TOGGLE_CNT), 32'd0);
    check_eq("clr_hit", 32'(bus.BUDGET_HIT), 32'd0);
    check_eq("clr_ready", 32'(bus.CMD_READY), 32'd1);
    step();
    bus.CMD_VALID = 1'b0;
    check_eq("clr_accept", 32'(bus.REG_MODO), 32'd1);
    step();
    check_eq("clr_done", 32'(bus.DONE), 32'd1);
    step();
    check_eq("clr_q", 32'(q_model), 32'd0);
    check_eq("clr_tcnt2", 32'(bus.TOGGLE_CNT), 32'd2);
    bus.BUDGET = 16'd0;

    // Zero-step shift right
    bus.CMD_VALID = 1'b1; bus.CMD_OP = 2'b10; bus.CMD_CNT = 3'd0;
    step();
    bus.CMD_VALID = 1'b0;
    check_eq("z_done", 32'(bus.DONE), 32'd1);
    check_eq("z_modo", 32'(bus.REG_MODO), 32'd0);
    step();
    check_eq("z_done_end", 32'(bus.DONE), 32'd0);
    check_eq("z_tcnt", 32'(bus.TOGGLE_CNT), 32'd2);

    // Shift left 4 with fill 1 from 0000
    bus.CMD_VALID = 1'b1; bus.CMD_OP = 2'b01; bus.CMD_CNT = 3'd4; bus.CMD_DATA = 4'b0001;
    step();
    bus.CMD_VALID = 1'b0; bus.CMD_DATA = 4'b0000; bus.CMD_OP = 2'b10;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("shl_modo%0d", i), 32'(bus.REG_MODO), 32'd2);
      check_eq($sformatf("shl_sin%0d", i), 32'(bus.REG_S_IN), 32'd1);
      step();
    end
    check_eq("shl_done", 32'(bus.DONE), 32'd1);
    check_eq("shl_q", 32'(q_model), 32'hF);

    // Reset in the middle of a 7-step rotate
    step();
    bus.CMD_VALID = 1'b1; bus.CMD_OP = 2'b11; bus.CMD_CNT = 3'd7;
    step();
    bus.CMD_VALID = 1'b0;
    step(); step(); step();
    check_eq("mid_modo", 32'(bus.REG_MODO), 32'd2);
    RESET_L = 1'b0;
    #2;
    check_eq("arst_modo", 32'(bus.REG_MODO), 32'd0);
    check_eq("arst_done", 32'(bus.DONE), 32'd0);
    check_eq("arst_tcnt", 32'(bus.TOGGLE_CNT), 32'd0);
    check_eq("arst_sin", 32'(bus.REG_S_IN), 32'd0);
    check_eq("arst_ready", 32'(bus.CMD_READY), 32'd1);
    step();
    RESET_L = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq($sformatf("post_done%0d", i), 32'(bus.DONE), 32'd0);
      check_eq($sformatf("post_modo%0d", i), 32'(bus.REG_MODO), 32'd0);
    end

    // Saturation of a 4-bit toggle counter
    for (int i = 0; i < 3; i++) begin
      q2 = ~q2;
      step();
    end
    check_eq("sat_pre", 32'(bus2.TOGGLE_CNT), 32'd12);
    for (int i = 0; i < 5; i++) begin
      q2 = ~q2;
      step();
    end
    check_eq("sat_hold", 32'(bus2.TOGGLE_CNT), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
